// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation encoding
// and a helper that classifies which operations advance the shift count.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROTL = 3'd3,
        MODE_ROTR = 3'd4,
        MODE_ASR  = 3'd5,
        MODE_LOAD = 3'd6
    } shift_mode_t;

    // Code 7 is reserved and deliberately not counted as a shift.
    function automatic logic is_shift(input shift_mode_t m);
        return (m == MODE_SHL)  || (m == MODE_SHR) || (m == MODE_ROTL) ||
               (m == MODE_ROTR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// Saturating shift counter with a registered one-cycle pulse on the shift
// that first brings the count up to WORDS.
module shift_cnt #(
    parameter int WORDS = 8,
    parameter int CW    = $clog2(WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] MAX = CW'(WORDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (inc && (cnt != MAX)) begin
                cnt <= cnt + CW'(1);
                // Only the transition into MAX pulses; shifts while saturated stay silent.
                done <= (cnt == MAX - CW'(1));
            end
        end
    end

endmodule

// File: rtl/uni_shift_reg.sv
// Universal shift register: load, shift, rotate and arithmetic shift by STEP
// bits, with the evicted bits on sout and a saturating shift count.
module uni_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    localparam int WORDS = WIDTH / STEP,
    localparam int CW    = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  shift_mode_t       mode,
    input  logic [STEP-1:0]   sin,
    input  logic [WIDTH-1:0]  pin,
    output logic [WIDTH-1:0]  out,
    output logic [STEP-1:0]   sout,
    output logic [CW-1:0]     cnt,
    output logic              done
);

    logic cnt_clr;
    logic cnt_inc;

    assign cnt_clr = en && (mode == MODE_LOAD);
    assign cnt_inc = en && is_shift(mode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            sout <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHL: begin
                    out  <= {out[WIDTH-STEP-1:0], sin};
                    sout <= out[WIDTH-1 -: STEP];
                end
                MODE_SHR: begin
                    out  <= {sin, out[WIDTH-1:STEP]};
                    sout <= out[STEP-1:0];
                end
                MODE_ROTL: begin
                    out  <= {out[WIDTH-STEP-1:0], out[WIDTH-1 -: STEP]};
                    sout <= out[WIDTH-1 -: STEP];
                end
                MODE_ROTR: begin
                    out  <= {out[STEP-1:0], out[WIDTH-1:STEP]};
                    sout <= out[STEP-1:0];
                end
                MODE_ASR: begin
                    out  <= {{STEP{out[WIDTH-1]}}, out[WIDTH-1:STEP]};
                    sout <= out[STEP-1:0];
                end
                MODE_LOAD: begin
                    out  <= pin;
                    sout <= '0;
                end
                default: begin
                    out  <= out;
                    sout <= sout;
                end
            endcase
        end
    end

    shift_cnt #(
        .WORDS (WORDS),
        .CW    (CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .done (done)
    );

endmodule

// File: tb/tb_uni_shift_reg.sv
// Directed bench for uni_shift_reg: one 8-bit/1-step instance and one
// 8-bit/2-step instance sharing clock and reset.
module tb_uni_shift_reg;
    import shift_pkg::*;

    logic clk;
    logic rst;

    // 8-bit, step 1
    logic        en_a;
    shift_mode_t mode_a;
    logic [0:0]  sin_a;
    logic [7:0]  pin_a;
    logic [7:0]  out_a;
    logic [0:0]  sout_a;
    logic [3:0]  cnt_a;
    logic        done_a;

    // 8-bit, step 2
    logic        en_b;
    shift_mode_t mode_b;
    logic [1:0]  sin_b;
    logic [7:0]  pin_b;
    logic [7:0]  out_b;
    logic [1:0]  sout_b;
    logic [2:0]  cnt_b;
    logic        done_b;

    int checks;
    int errors;

    uni_shift_reg #(.WIDTH(8), .STEP(1)) u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .en   (en_a),
        .mode (mode_a),
        .sin  (sin_a),
        .pin  (pin_a),
        .out  (out_a),
        .sout (sout_a),
        .cnt  (cnt_a),
        .done (done_a)
    );

    uni_shift_reg #(.WIDTH(8), .STEP(2)) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .en   (en_b),
        .mode (mode_b),
        .sin  (sin_b),
        .pin  (pin_b),
        .out  (out_b),
        .sout (sout_b),
        .cnt  (cnt_b),
        .done (done_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: set inputs, take one edge, settle past it
    task automatic drive_a(input logic e, input shift_mode_t m, input logic s, input logic [7:0] p);
        en_a   = e;
        mode_a = m;
        sin_a  = s;
        pin_a  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic e, input shift_mode_t m, input logic [1:0] s, input logic [7:0] p);
        en_b   = e;
        mode_b = m;
        sin_b  = s;
        pin_b  = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        en_a = 1'b0; mode_a = MODE_HOLD; sin_a = '0; pin_a = '0;
        en_b = 1'b0; mode_b = MODE_HOLD; sin_b = '0; pin_b = '0;

        #1;
        check("rst_out_a",  out_a,  8'h00);
        check("rst_sout_a", sout_a, 1'b0);
        check("rst_cnt_a",  cnt_a,  4'd0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_out_b",  out_b,  8'h00);

        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // LOAD then SHL with sin=1
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'hA5);
        check("load_out",  out_a,  8'hA5);
        check("load_cnt",  cnt_a,  4'd0);
        check("load_sout", sout_a, 1'b0);
        drive_a(1'b1, MODE_SHL, 1'b1, 8'h00);
        check("shl_out",  out_a,  8'h4B);
        check("shl_sout", sout_a, 1'b1);
        check("shl_cnt",  cnt_a,  4'd1);

        // rotates
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'h81);
        drive_a(1'b1, MODE_ROTR, 1'b0, 8'h00);
        check("rotr_out",  out_a,  8'hC0);
        check("rotr_sout", sout_a, 1'b1);
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'h81);
        drive_a(1'b1, MODE_ROTL, 1'b0, 8'h00);
        check("rotl_out",  out_a,  8'h03);
        check("rotl_sout", sout_a, 1'b1);

        // arithmetic shift ignores sin
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'h80);
        drive_a(1'b1, MODE_ASR, 1'b0, 8'h00);
        check("asr1_out", out_a, 8'hC0);
        drive_a(1'b1, MODE_ASR, 1'b1, 8'h00);
        drive_a(1'b1, MODE_ASR, 1'b0, 8'h00);
        check("asr3_out",  out_a,  8'hF0);
        check("asr3_sout", sout_a, 1'b0);
        check("asr3_cnt",  cnt_a,  4'd3);

        // full-word SHR with saturation
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'hFF);
        for (int i = 1; i <= 7; i++) begin
            drive_a(1'b1, MODE_SHR, 1'b0, 8'h00);
            check("shr_nodone", done_a, 1'b0);
        end
        check("shr7_out", out_a, 8'h01);
        drive_a(1'b1, MODE_SHR, 1'b0, 8'h00);
        check("shr8_out",  out_a,  8'h00);
        check("shr8_cnt",  cnt_a,  4'd8);
        check("shr8_done", done_a, 1'b1);
        check("shr8_sout", sout_a, 1'b1);
        drive_a(1'b1, MODE_SHR, 1'b0, 8'h00);
        check("shr9_done", done_a, 1'b0);
        check("shr9_cnt",  cnt_a,  4'd8);
        check("shr9_sout", sout_a, 1'b0);

        // LOAD right after saturation rearms the pulse
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'h0F);
        check("reload_cnt",  cnt_a,  4'd0);
        check("reload_done", done_a, 1'b0);
        for (int i = 1; i <= 7; i++) drive_a(1'b1, MODE_SHL, 1'b0, 8'h00);
        check("rearm7_done", done_a, 1'b0);
        drive_a(1'b1, MODE_SHL, 1'b0, 8'h00);
        check("rearm8_done", done_a, 1'b1);
        check("rearm8_out",  out_a,  8'h00);

        // en=0 and reserved code freeze state
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'h3C);
        drive_a(1'b1, MODE_SHL, 1'b0, 8'h00);
        check("pre_freeze_out", out_a, 8'h78);
        drive_a(1'b0, MODE_SHL, 1'b1, 8'h00);
        check("en0_out",  out_a,  8'h78);
        check("en0_cnt",  cnt_a,  4'd1);
        check("en0_sout", sout_a, 1'b0);
        drive_a(1'b0, MODE_LOAD, 1'b0, 8'hAA);
        check("en0_load_out", out_a, 8'h78);
        drive_a(1'b1, MODE_HOLD, 1'b1, 8'h00);
        check("hold_out", out_a, 8'h78);
        check("hold_cnt", cnt_a, 4'd1);
        drive_a(1'b1, shift_mode_t'(3'd7), 1'b1, 8'hAA);
        check("rsvd_out", out_a, 8'h78);
        check("rsvd_cnt", cnt_a, 4'd1);
        drive_a(1'b1, MODE_SHL, 1'b1, 8'h00);
        check("resume_out", out_a, 8'hF1);
        check("resume_cnt", cnt_a, 4'd2);

        // asynchronous reset in the middle of a shift run
        drive_a(1'b1, MODE_LOAD, 1'b0, 8'hFF);
        drive_a(1'b1, MODE_SHR, 1'b0, 8'h00);
        drive_a(1'b1, MODE_SHR, 1'b0, 8'h00);
        drive_a(1'b1, MODE_SHR, 1'b0, 8'h00);
        check("pre_rst_cnt", cnt_a, 4'd3);
        #2 rst = 1'b0;
        #1;
        check("async_out",  out_a,  8'h00);
        check("async_cnt",  cnt_a,  4'd0);
        check("async_done", done_a, 1'b0);
        check("async_sout", sout_a, 1'b0);
        en_a = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        drive_a(1'b1, MODE_SHL, 1'b1, 8'h00);
        check("post_rst_out", out_a, 8'h01);
        check("post_rst_cnt", cnt_a, 4'd1);
        en_a = 1'b0;

        // step-2 instance
        drive_b(1'b1, MODE_LOAD, 2'b00, 8'hF0);
        check("s2_load_out", out_b, 8'hF0);
        drive_b(1'b1, MODE_SHL, 2'b01, 8'h00);
        check("s2_shl_out",  out_b,  8'hC1);
        check("s2_shl_sout", sout_b, 2'b11);
        check("s2_shl_cnt",  cnt_b,  3'd1);
        drive_b(1'b1, MODE_SHL, 2'b10, 8'h00);
        check("s2_shl2_out", out_b, 8'h06);
        drive_b(1'b1, MODE_SHL, 2'b00, 8'h00);
        check("s2_3_done", done_b, 1'b0);
        drive_b(1'b1, MODE_SHL, 2'b11, 8'h00);
        check("s2_4_done", done_b, 1'b1);
        check("s2_4_cnt",  cnt_b,  3'd4);
        check("s2_4_out",  out_b,  8'h63);
        drive_b(1'b1, MODE_ROTR, 2'b00, 8'h00);
        check("s2_5_done", done_b, 1'b0);
        check("s2_rotr_out",  out_b,  8'hD8);
        check("s2_rotr_sout", sout_b, 2'b11);
        en_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
